combi_mode_ctrl: RTL and testbench

- Sequences the ISA mode (ARM vs RISC-V) of the combined decode stage.
- Consumes per-instruction validity flags from both sub-decoders and the pipeline flush/stall state.
- Drives the armIn mode bit back to the decoder, and requests a fetch flush plus drain window on every ISA switch.
- Raises an undefined-instruction trap with a handshake, and flags long runs of ambiguous encodings.

---
 rtl/combi_pkg.sv | 10 +
 rtl/combi_mode_classify.sv | 15 +
 rtl/combi_mode_ctrl.sv | 76 +++++++
 tb/tb_combi_mode_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/combi_pkg.sv
// combi_pkg: shared types and ISA encodings for the combined-decode mode controller
package combi_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, TRAP} mode_state_t;
  typedef enum logic [1:0] {AMB, RV, ARM, ILL} instr_class_t;
  localparam logic ISA_ARM = 1'b1;
  localparam logic ISA_RV = 1'b0;
  function automatic logic class_mode(input instr_class_t c);
    return c == ARM ? ISA_ARM : ISA_RV;
  endfunction
endpackage

// File: rtl/combi_mode_classify.sv
// combi_mode_classify: qualifies the instruction in D and classifies it by sub-decoder legality
module combi_mode_classify
  import combi_pkg::*;
(
  input  logic         rv_valid,
  input  logic         arm_valid,
  input  logic         instr_valid,
  input  logic         stall,
  input  logic         flush,
  output logic         act,
  output instr_class_t cls
);
  assign act = instr_valid & ~stall & ~flush;
  assign cls = rv_valid ? (arm_valid ? AMB : RV) : (arm_valid ? ARM : ILL);
endmodule

// File: rtl/combi_mode_ctrl.sv
// combi_mode_ctrl: sequences ARM/RISC-V decode mode with switch flush/drain, trap handshake and ambiguity tracking
module combi_mode_ctrl
  import combi_pkg::*;
#(
  parameter int   DRAIN_CYCLES = 2,
  parameter int   AMBIG_LIMIT  = 8,
  parameter logic RESET_ARM    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic RVValidD,
  input  logic ARMValidD,
  input  logic InstrValidD,
  input  logic StallD,
  input  logic FlushD,
  input  logic TrapAck,
  output logic armIn,
  output logic SwitchFlushF,
  output logic StallReqD,
  output logic TrapD,
  output logic AmbigSat,
  output logic ModeQ
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int AW = $clog2(AMBIG_LIMIT + 1);
  logic         act, sel, opp, sw;
  instr_class_t cls;
  mode_state_t  state, state_n;
  logic [DW-1:0] drain_cnt;
  logic [AW-1:0] amb_cnt;
  combi_mode_classify u_classify (
    .rv_valid   (RVValidD),
    .arm_valid  (ARMValidD),
    .instr_valid(InstrValidD),
    .stall      (StallD),
    .flush      (FlushD),
    .act        (act),
    .cls        (cls)
  );
  assign sel = act & (cls == RV || cls == ARM);
  assign opp = sel & (class_mode(cls) != ModeQ);
  // an opposite-ISA instruction during drain is held in the old mode until RUN
  assign armIn = sel && !(state == DRAIN && opp) ? class_mode(cls) : ModeQ;
  assign StallReqD = state == TRAP || (state == DRAIN && opp);
  assign TrapD = state == TRAP;
  assign AmbigSat = amb_cnt == AW'(AMBIG_LIMIT);
  always_comb begin
    state_n = state;
    sw = 1'b0;
    if (state == TRAP) state_n = TrapAck ? RUN : TRAP;
    else if (act && cls == ILL) state_n = TRAP;
    else if (state == RUN && opp) begin
      state_n = DRAIN;
      sw = 1'b1;
    end
    else if (state == DRAIN && drain_cnt <= DW'(1)) state_n = RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      ModeQ <= RESET_ARM;
      SwitchFlushF <= 1'b0;
      drain_cnt <= '0;
      amb_cnt <= '0;
    end else begin
      state <= state_n;
      SwitchFlushF <= sw;
      if (sw) begin
        ModeQ <= class_mode(cls);
        drain_cnt <= DW'(DRAIN_CYCLES);
      end else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      if (act && cls == AMB && !AmbigSat) amb_cnt <= amb_cnt + 1'b1;
      else if (sel) amb_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_combi_mode_ctrl.sv
// tb_combi_mode_ctrl: directed self-checking bench for combi_mode_ctrl
module tb_combi_mode_ctrl;
  logic clk = 1'b0;
  logic reset, RVValidD, ARMValidD, InstrValidD, StallD, FlushD, TrapAck;
  logic armIn, SwitchFlushF, StallReqD, TrapD, AmbigSat, ModeQ;
  int n_checks = 0;
  int n_fail = 0;
  combi_mode_ctrl #(.DRAIN_CYCLES(2), .AMBIG_LIMIT(8), .RESET_ARM(1'b0)) dut (
    .clk(clk), .reset(reset), .RVValidD(RVValidD), .ARMValidD(ARMValidD),
    .InstrValidD(InstrValidD), .StallD(StallD), .FlushD(FlushD), .TrapAck(TrapAck),
    .armIn(armIn), .SwitchFlushF(SwitchFlushF), .StallReqD(StallReqD),
    .TrapD(TrapD), .AmbigSat(AmbigSat), .ModeQ(ModeQ)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic r, input logic a, input logic v, input logic f);
    RVValidD = r;
    ARMValidD = a;
    InstrValidD = v;
    FlushD = f;
    #1;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    StallD = 1'b0;
    TrapAck = 1'b0;
    drive(0, 0, 0, 0);
    step;
    step;
  endtask
  task automatic test_reset;
    do_reset;
    n_checks++; if (ModeQ !== 1'b0) begin n_fail++; $display("FAIL reset_modeq got %b exp 0", ModeQ); end
    n_checks++; if ({SwitchFlushF, StallReqD, TrapD, AmbigSat} !== 4'b0) begin n_fail++; $display("FAIL reset_outs got %b exp 0000", {SwitchFlushF, StallReqD, TrapD, AmbigSat}); end
    n_checks++; if (armIn !== 1'b0) begin n_fail++; $display("FAIL reset_armin got %b exp 0", armIn); end
    reset = 1'b0;
  endtask
  task automatic test_rv_stay;
    drive(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (armIn !== 1'b0) begin n_fail++; $display("FAIL rv_armin[%0d] got %b exp 0", i, armIn); end
      step;
      n_checks++; if ({ModeQ, SwitchFlushF, StallReqD} !== 3'b000) begin n_fail++; $display("FAIL rv_stay[%0d] got %b exp 000", i, {ModeQ, SwitchFlushF, StallReqD}); end
    end
  endtask
  task automatic test_switch;
    drive(0, 1, 1, 0);
    n_checks++; if ({armIn, SwitchFlushF} !== 2'b10) begin n_fail++; $display("FAIL sw_pre got %b exp 10", {armIn, SwitchFlushF}); end
    step;
    drive(0, 0, 0, 0);
    n_checks++; if ({ModeQ, SwitchFlushF} !== 2'b11) begin n_fail++; $display("FAIL sw_edge got %b exp 11", {ModeQ, SwitchFlushF}); end
    step;
    n_checks++; if ({ModeQ, SwitchFlushF} !== 2'b10) begin n_fail++; $display("FAIL sw_pulse_end got %b exp 10", {ModeQ, SwitchFlushF}); end
    step;
    drive(1, 0, 1, 0);
    n_checks++; if ({StallReqD, armIn} !== 2'b00) begin n_fail++; $display("FAIL sw_run_again got %b exp 00", {StallReqD, armIn}); end
    drive(0, 0, 0, 0);
  endtask
  task automatic test_drain_stall;
    do_reset;
    reset = 1'b0;
    drive(0, 1, 1, 0);
    step;
    drive(1, 0, 1, 0);
    n_checks++; if ({StallReqD, armIn, ModeQ} !== 3'b111) begin n_fail++; $display("FAIL drain_hold1 got %b exp 111", {StallReqD, armIn, ModeQ}); end
    step;
    n_checks++; if ({StallReqD, armIn, ModeQ, SwitchFlushF} !== 4'b1110) begin n_fail++; $display("FAIL drain_hold2 got %b exp 1110", {StallReqD, armIn, ModeQ, SwitchFlushF}); end
    step;
    n_checks++; if ({StallReqD, armIn, ModeQ} !== 3'b001) begin n_fail++; $display("FAIL drain_release got %b exp 001", {StallReqD, armIn, ModeQ}); end
    step;
    drive(0, 0, 0, 0);
    n_checks++; if ({ModeQ, SwitchFlushF} !== 2'b01) begin n_fail++; $display("FAIL drain_switch_back got %b exp 01", {ModeQ, SwitchFlushF}); end
    step;
    step;
  endtask
  task automatic test_trap;
    do_reset;
    reset = 1'b0;
    drive(0, 0, 1, 0);
    n_checks++; if (TrapD !== 1'b0) begin n_fail++; $display("FAIL trap_pre got %b exp 0", TrapD); end
    step;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({TrapD, StallReqD} !== 2'b11) begin n_fail++; $display("FAIL trap_hold[%0d] got %b exp 11", i, {TrapD, StallReqD}); end
      step;
    end
    TrapAck = 1'b1;
    #1;
    n_checks++; if (TrapD !== 1'b1) begin n_fail++; $display("FAIL trap_ack_cycle got %b exp 1", TrapD); end
    step;
    TrapAck = 1'b0;
    n_checks++; if ({TrapD, StallReqD, ModeQ} !== 3'b000) begin n_fail++; $display("FAIL trap_exit got %b exp 000", {TrapD, StallReqD, ModeQ}); end
  endtask
  task automatic test_ambig;
    do_reset;
    reset = 1'b0;
    drive(1, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if ({armIn, AmbigSat} !== 2'b00) begin n_fail++; $display("FAIL amb_run[%0d] got %b exp 00", i, {armIn, AmbigSat}); end
      step;
    end
    n_checks++; if (AmbigSat !== 1'b1) begin n_fail++; $display("FAIL amb_sat got %b exp 1", AmbigSat); end
    step;
    n_checks++; if ({AmbigSat, ModeQ, SwitchFlushF} !== 3'b100) begin n_fail++; $display("FAIL amb_sat9 got %b exp 100", {AmbigSat, ModeQ, SwitchFlushF}); end
    drive(1, 0, 1, 0);
    step;
    n_checks++; if (AmbigSat !== 1'b0) begin n_fail++; $display("FAIL amb_clear got %b exp 0", AmbigSat); end
    drive(0, 0, 0, 0);
  endtask
  task automatic test_flush_and_reset;
    do_reset;
    reset = 1'b0;
    drive(0, 1, 1, 1);
    n_checks++; if (armIn !== 1'b0) begin n_fail++; $display("FAIL flush_armin got %b exp 0", armIn); end
    step;
    n_checks++; if ({ModeQ, SwitchFlushF} !== 2'b00) begin n_fail++; $display("FAIL flush_noswitch got %b exp 00", {ModeQ, SwitchFlushF}); end
    drive(0, 1, 1, 0);
    step;
    drive(0, 0, 0, 0);
    n_checks++; if ({ModeQ, SwitchFlushF} !== 2'b11) begin n_fail++; $display("FAIL mid_drain_setup got %b exp 11", {ModeQ, SwitchFlushF}); end
    reset = 1'b1;
    step;
    n_checks++; if ({ModeQ, SwitchFlushF, StallReqD, TrapD, AmbigSat} !== 5'b0) begin n_fail++; $display("FAIL mid_drain_reset got %b exp 00000", {ModeQ, SwitchFlushF, StallReqD, TrapD, AmbigSat}); end
    reset = 1'b0;
    drive(0, 1, 1, 0);
    n_checks++; if ({StallReqD, armIn} !== 2'b01) begin n_fail++; $display("FAIL post_reset_run got %b exp 01", {StallReqD, armIn}); end
    drive(0, 0, 0, 0);
  endtask
  initial begin
    test_reset;
    test_rv_stay;
    test_switch;
    test_drain_stall;
    test_trap;
    test_ambig;
    test_flush_and_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
